dac_parallel_tx: RTL and testbench
==================================

Name: dac_parallel_tx

Overview:
- Transmit-side counterpart to the team's parallel 12-bit ADC capture path: feeds a parallel-input DAC (offset-binary, latches on dac_clk rising edge).
- Samples arrive on a valid/ready stream into an internal FIFO and are played out at a programmable rate.
- Also generates the DAC sample clock.
- Sits between the UART/command logic or a waveform source and the DAC pins.

Parameters:
- DATA_W, 12, sample width (DAC bus width).
- DEPTH, 16, FIFO depth in samples; power of two, at least 2.
- DIV_W, 16, width of rate_div.
- MIDSCALE, 2048, reset/idle value driven on dac_data (offset-binary zero).

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- s_data, input, DATA_W, sample to enqueue.
- s_valid, input, 1, s_data valid.
- s_ready, output, 1, FIFO can accept; a push occurs when s_valid and s_ready are both high.
- enable, input, 1, playout enable.
- rate_div, input, DIV_W, playout period minus 1 in clk cycles; 0 is treated as 1.
- underrun_clr, input, 1, clears the sticky underrun flag.
- dac_data, output, DATA_W, registered DAC data bus.
- dac_clk, output, 1, registered DAC latch clock.
- underrun, output, 1, sticky flag: a playout slot found the FIFO empty.
- fifo_level, output, $clog2(DEPTH)+1, number of samples held.

Behaviour:
- Reset (async assert, sync release):
  - dac_data=MIDSCALE, dac_clk=0, underrun=0, fifo_level=0.
  - FIFO empty, s_ready=1, period counter cnt=0.
- FIFO:
  - s_ready = (fifo_level != DEPTH), registered-equivalent (no combinational path from s_valid).
  - Push when s_valid & s_ready. Pop only on a playout strobe when not empty.
  - Simultaneous push and pop: level unchanged.
  - No fall-through: a sample pushed in cycle N is poppable from cycle N+1.
  - Pointers wrap modulo DEPTH. At full, s_ready=0; a held s_valid is not lost and is accepted once a pop frees space.
- Period counter:
  - P = max(rate_div,1)+1.
  - While enable=1: cnt counts 0..P-1 and wraps. The strobe occurs on the clock edge where cnt==P-1.
  - rate_div is sampled at wrap; a change mid-period takes effect in the next period.
- Playout on strobe:
  - If FIFO not empty: dac_data <= head sample, pop.
  - If empty: dac_data holds its previous value and underrun <= 1.
  - dac_data changes on the same edge that cnt returns to 0.
- dac_clk:
  - Registered together with cnt: 0 while cnt < P/2 (integer division), 1 otherwise.
  - The rising edge therefore occurs P/2 cycles after the data change, and data is stable across it.
  - Example, rate_div=3 (P=4): dac_clk pattern 0,0,1,1; data changes at the first 0.
- enable=0:
  - cnt forced to 0, dac_clk=0, no strobes, dac_data holds.
  - FIFO still accepts pushes.
  - Deassertion mid-period aborts the period; on re-enable the first strobe comes P cycles later.
- underrun:
  - Stays set until underrun_clr=1.
  - If clear and a new underrun happen in the same cycle, set wins.
- Reset mid-operation discards FIFO contents and returns every output to its reset value immediately.

Test Plan:
- Reset, enable=1, rate_div=3, FIFO empty:
  - dac_data stays 0x800.
  - dac_clk toggles 0,0,1,1 per period.
  - underrun=1 after the first strobe (4 cycles after enable).
- Push 0x001,0x7FF,0xFFF then enable with rate_div=1:
  - dac_data shows 0x001, 0x7FF, 0xFFF for 2 cycles each, dac_clk rising mid-slot.
  - Then dac_data holds 0xFFF and underrun sets on the 4th strobe.
- With enable=0, push 17 samples continuously (DEPTH=16):
  - s_ready drops after the 16th push, fifo_level=16, 17th sample held on s_data.
  - Enable: after the first pop the 17th is accepted and level stays 16.
- rate_div=0:
  - Behaves as P=2: one pop every 2 cycles, dac_clk alternates 0/1.
- Assert underrun_clr in the same cycle as an empty-FIFO strobe -> underrun remains 1.
- Next cycle assert underrun_clr alone -> underrun=0.
- Assert rst_n=0 asynchronously mid-playout with fifo_level=5:
  - Outputs go to 0x800/0/0/0 without waiting for a clock edge.
  - After release, the FIFO is empty and s_ready=1.

Source files
------------

// File: rtl/dac_parallel_tx.sv
// ---------------------------------------------------------------------------
// dac_parallel_tx
//
// Purpose:
//   Transmit path for a parallel-input, offset-binary DAC. Samples arrive on a
//   valid/ready stream, are buffered in a small FIFO, and are played out at a
//   programmable rate. The block also generates the DAC latch clock so that
//   data is always stable around the DAC's rising-edge latch point.
//
// Ports:
//   clk          in   system clock, all logic on the rising edge
//   rst_n        in   asynchronous active-low reset
//   s_data       in   sample to enqueue (DATA_W)
//   s_valid      in   s_data valid
//   s_ready      out  FIFO can accept a sample
//   enable       in   playout enable
//   rate_div     in   playout period minus 1 in clk cycles (0 behaves as 1)
//   underrun_clr in   clears the sticky underrun flag
//   dac_data     out  registered DAC data bus
//   dac_clk      out  registered DAC latch clock
//   underrun     out  sticky: a playout slot found the FIFO empty
//   fifo_level   out  number of samples currently buffered
//
// Handshake: a sample is transferred on a rising clk edge where s_valid and
// s_ready are both high. s_ready depends only on registered state, never on
// s_valid. A producer holding s_valid while s_ready is low keeps its sample;
// it is taken on the first edge where s_ready is high again.
// ---------------------------------------------------------------------------
module dac_parallel_tx #(
    parameter int DATA_W   = 12,
    parameter int DEPTH    = 16,
    parameter int DIV_W    = 16,
    parameter int MIDSCALE = 2048
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic                     enable,
    input  logic [DIV_W-1:0]         rate_div,
    input  logic                     underrun_clr,
    output logic [DATA_W-1:0]        dac_data,
    output logic                     dac_clk,
    output logic                     underrun,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // FIFO storage and pointers; pointers carry one extra wrap bit so that
    // full and empty are distinguishable from the pointer difference alone.
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;

    // Playout timing
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  period_q, period_d;  // P-1 for the period in progress
    logic [DIV_W-1:0]  rate_eff;
    logic [DIV_W-1:0]  lim_cur;
    logic [DIV_W:0]    half;
    logic              strobe;

    // Output registers
    logic [DATA_W-1:0] dac_data_q, dac_data_d;
    logic              dac_clk_q, dac_clk_d;
    logic              underrun_q, underrun_d;

    logic              push;
    logic              pop;
    logic              empty;

    assign fifo_level = wr_ptr_q - rd_ptr_q;
    assign s_ready    = (fifo_level != LW'(DEPTH));
    assign empty      = (fifo_level == '0);

    always_comb begin
        rate_eff = (rate_div == '0) ? DIV_W'(1) : rate_div;
        // rate_div is only looked at when a period starts (cnt == 0); for the
        // rest of the period the captured value is used, so a mid-period
        // change only affects the next period.
        lim_cur  = (cnt_q == '0) ? rate_eff : period_q;
        period_d = lim_cur;
        strobe   = enable && (cnt_q == lim_cur);
        // P/2 with P = lim_cur + 1, computed one bit wider to avoid overflow
        half     = ({1'b0, lim_cur} + (DIV_W+1)'(1)) >> 1;

        if (!enable) begin
            cnt_d = '0;
        end else if (strobe) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end

        // dac_clk follows the new counter value; cnt_d == 0 is always below
        // half, so the data-change edge always drives dac_clk low.
        dac_clk_d = enable && ({1'b0, cnt_d} >= half);

        push = s_valid && s_ready;
        pop  = strobe && !empty;

        wr_ptr_d = push ? (wr_ptr_q + LW'(1)) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + LW'(1)) : rd_ptr_q;

        dac_data_d = pop ? mem_q[rd_ptr_q[AW-1:0]] : dac_data_q;

        // A new underrun wins over a clear in the same cycle.
        if (strobe && empty) begin
            underrun_d = 1'b1;
        end else if (underrun_clr) begin
            underrun_d = 1'b0;
        end else begin
            underrun_d = underrun_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            period_q   <= DIV_W'(1);
            dac_data_q <= DATA_W'(MIDSCALE);
            dac_clk_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            dac_data_q <= dac_data_d;
            dac_clk_q  <= dac_clk_d;
            underrun_q <= underrun_d;
        end
    end

    // Storage is not reset: the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= s_data;
        end
    end

    assign dac_data = dac_data_q;
    assign dac_clk  = dac_clk_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_dac_parallel_tx.sv
module tb_dac_parallel_tx;

  localparam int DATA_W = 12;
  localparam int DEPTH  = 16;
  localparam int DIV_W  = 16;
  localparam logic [DATA_W-1:0] MID = 12'h800;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DATA_W-1:0]      s_data = '0;
  logic                   s_valid = 1'b0;
  logic                   s_ready;
  logic                   enable = 1'b0;
  logic [DIV_W-1:0]       rate_div = '0;
  logic                   underrun_clr = 1'b0;
  logic [DATA_W-1:0]      dac_data;
  logic                   dac_clk;
  logic                   underrun;
  logic [$clog2(DEPTH):0] fifo_level;

  dac_parallel_tx #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .DIV_W(DIV_W), .MIDSCALE(2048)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .enable(enable), .rate_div(rate_div), .underrun_clr(underrun_clr),
    .dac_data(dac_data), .dac_clk(dac_clk), .underrun(underrun),
    .fifo_level(fifo_level)
  );

  int total = 0;
  int bad = 0;

  // Reference model: samples held in a queue; playout timing computed from
  // the number of enabled cycles k and the period P fixed when enable rises
  // (the bench only changes rate_div while enable is low).
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] m_data;
  bit                m_clk;
  bit                m_und;
  bit                m_pushed;
  int                m_k;
  int                m_p;

  task automatic model_reset();
    exp_q.delete();
    m_data = MID; m_clk = 0; m_und = 0; m_k = 0; m_p = 2; m_pushed = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven,
  // then let the DUT take the same edge and sample 1ns later.
  task automatic clk_step();
    bit was_empty, rdy, strobe;
    was_empty = (exp_q.size() == 0);
    rdy = (exp_q.size() != DEPTH);
    m_pushed = s_valid && rdy;
    strobe = 0;
    if (enable) begin
      m_k++;
      if (m_k == 1) m_p = ((rate_div == 0) ? 1 : int'(rate_div)) + 1;
      strobe = ((m_k % m_p) == 0);
      m_clk = ((m_k % m_p) >= (m_p / 2));
    end else begin
      m_k = 0;
      m_clk = 0;
    end
    if (strobe && was_empty) m_und = 1;
    else if (underrun_clr) m_und = 0;
    if (strobe && !was_empty) m_data = exp_q.pop_front();
    if (m_pushed) exp_q.push_back(s_data);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    enable = 0; s_valid = 0; underrun_clr = 0;
    #2 rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (dac_data !== MID) begin bad++; $display("FAIL reset_data got=%h exp=%h", dac_data, MID); end
    total++; if (dac_clk !== 1'b0) begin bad++; $display("FAIL reset_clk got=%b exp=0", dac_clk); end
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
    total++; if (fifo_level !== 0) begin bad++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", s_ready); end
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_empty_playout();
    do_reset();
    rate_div = 3; enable = 1;
    for (int c = 1; c <= 12; c++) begin
      clk_step();
      total++;
      if ({dac_data, dac_clk, underrun, fifo_level} !== {m_data, m_clk, m_und, 5'(exp_q.size())}) begin
        bad++;
        $display("FAIL empty_playout cyc=%0d data=%h/%h clk=%b/%b und=%b/%b lvl=%0d/%0d",
                 c, dac_data, m_data, dac_clk, m_clk, underrun, m_und, fifo_level, exp_q.size());
      end
      if (c == 3) begin
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL empty_und_early cyc=3 got=%b exp=0", underrun); end
      end
      if (c == 4) begin
        total++; if (underrun !== 1'b1) begin bad++; $display("FAIL empty_und_first_strobe cyc=4 got=%b exp=1", underrun); end
      end
    end
    enable = 0;
  endtask

  task automatic test_playout_sequence();
    logic [DATA_W-1:0] vals[3];
    logic [DATA_W-1:0] exp_data[10];
    vals = '{12'h001, 12'h7FF, 12'hFFF};
    exp_data = '{MID, 12'h001, 12'h001, 12'h7FF, 12'h7FF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      s_data = vals[i]; s_valid = 1;
      clk_step();
    end
    s_valid = 0;
    total++; if (fifo_level !== 3) begin bad++; $display("FAIL seq_level got=%0d exp=3", fifo_level); end
    rate_div = 1; enable = 1;
    for (int c = 1; c <= 10; c++) begin
      clk_step();
      total++;
      if (dac_data !== exp_data[c-1] || dac_clk !== (c % 2 == 1) || underrun !== (c >= 8)) begin
        bad++;
        $display("FAIL seq_playout cyc=%0d data=%h/%h clk=%b/%b und=%b/%b",
                 c, dac_data, exp_data[c-1], dac_clk, (c % 2 == 1), underrun, (c >= 8));
      end
      total++;
      if ({dac_data, dac_clk, underrun} !== {m_data, m_clk, m_und}) begin
        bad++;
        $display("FAIL seq_model cyc=%0d data=%h/%h clk=%b/%b und=%b/%b",
                 c, dac_data, m_data, dac_clk, m_clk, underrun, m_und);
      end
    end
    enable = 0;
  endtask

  task automatic test_full();
    int guard;
    do_reset();
    s_valid = 1;
    for (int i = 0; i < DEPTH; i++) begin
      s_data = 12'h100 + 12'(i);
      clk_step();
    end
    s_data = 12'h1AA;
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", s_ready); end
    total++; if (fifo_level !== 16) begin bad++; $display("FAIL full_level got=%0d exp=16", fifo_level); end
    repeat (3) clk_step();
    total++; if (fifo_level !== 5'(exp_q.size())) begin bad++; $display("FAIL full_hold_level got=%0d exp=%0d", fifo_level, exp_q.size()); end
    rate_div = 1; enable = 1;
    guard = 0;
    do begin
      clk_step();
      guard++;
    end while (!m_pushed && guard < 10);
    total++; if (guard >= 10) begin bad++; $display("FAIL full_accept_timeout got=%0d cycles exp<10", guard); end
    total++; if (fifo_level !== 16) begin bad++; $display("FAIL full_after_accept got=%0d exp=16", fifo_level); end
    s_valid = 0;
    for (int c = 0; c < 40; c++) begin
      clk_step();
      total++;
      if ({dac_data, dac_clk, underrun, fifo_level, s_ready} !== {m_data, m_clk, m_und, 5'(exp_q.size()), exp_q.size() != DEPTH}) begin
        bad++;
        $display("FAIL full_drain cyc=%0d data=%h/%h clk=%b/%b und=%b/%b lvl=%0d/%0d",
                 c, dac_data, m_data, dac_clk, m_clk, underrun, m_und, fifo_level, exp_q.size());
      end
    end
    total++; if (dac_data !== 12'h1AA) begin bad++; $display("FAIL full_last_sample got=%h exp=1aa", dac_data); end
    enable = 0;
  endtask

  task automatic test_rate0();
    do_reset();
    s_valid = 1;
    for (int i = 0; i < 6; i++) begin
      s_data = 12'($urandom_range(0, 4095));
      clk_step();
    end
    s_valid = 0;
    rate_div = 0; enable = 1;
    for (int c = 1; c <= 16; c++) begin
      clk_step();
      total++;
      if (dac_clk !== (c % 2 == 1) || fifo_level !== 5'(6 - ((c / 2 > 6) ? 6 : c / 2))) begin
        bad++;
        $display("FAIL rate0_timing cyc=%0d clk=%b/%b lvl=%0d/%0d", c, dac_clk, (c % 2 == 1),
                 fifo_level, 6 - ((c / 2 > 6) ? 6 : c / 2));
      end
      total++;
      if ({dac_data, underrun} !== {m_data, m_und}) begin
        bad++;
        $display("FAIL rate0_data cyc=%0d data=%h/%h und=%b/%b", c, dac_data, m_data, underrun, m_und);
      end
    end
    enable = 0;
  endtask

  task automatic test_underrun_clr();
    do_reset();
    rate_div = 3; enable = 1;
    repeat (3) clk_step();
    underrun_clr = 1;
    clk_step();
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL clr_vs_set got=%b exp=1", underrun); end
    clk_step();
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL clr_alone got=%b exp=0", underrun); end
    underrun_clr = 0;
    clk_step();
    total++; if (underrun !== m_und) begin bad++; $display("FAIL clr_model got=%b exp=%b", underrun, m_und); end
    enable = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if (c % 50 == 0) begin
        enable = 0;
        rate_div = 16'($urandom_range(0, 4));
      end else if (c % 50 == 2) begin
        enable = 1;
      end
      s_valid = ($urandom_range(0, 99) < ((c % 200 < 100) ? 75 : 10));
      s_data = 12'($urandom_range(0, 4095));
      underrun_clr = ($urandom_range(0, 15) == 0);
      clk_step();
      total++;
      if ({dac_data, dac_clk, underrun, fifo_level, s_ready} !== {m_data, m_clk, m_und, 5'(exp_q.size()), exp_q.size() != DEPTH}) begin
        bad++;
        $display("FAIL random cyc=%0d data=%h/%h clk=%b/%b und=%b/%b lvl=%0d/%0d rdy=%b",
                 c, dac_data, m_data, dac_clk, m_clk, underrun, m_und, fifo_level, exp_q.size(), s_ready);
      end
    end
    enable = 0; s_valid = 0; underrun_clr = 0;
  endtask

  task automatic test_async_reset();
    int guard;
    do_reset();
    s_valid = 1;
    for (int i = 0; i < 8; i++) begin
      s_data = 12'h300 + 12'(i);
      clk_step();
    end
    s_valid = 0;
    rate_div = 2; enable = 1;
    guard = 0;
    while (exp_q.size() != 5 && guard < 30) begin
      clk_step();
      guard++;
    end
    total++; if (fifo_level !== 5) begin bad++; $display("FAIL async_pre_level got=%0d exp=5", fifo_level); end
    total++; if (dac_data !== 12'h302) begin bad++; $display("FAIL async_pre_data got=%h exp=302", dac_data); end
    #2 rst_n = 0;
    #1;
    total++;
    if ({dac_data, dac_clk, underrun, fifo_level} !== {MID, 1'b0, 1'b0, 5'd0}) begin
      bad++;
      $display("FAIL async_reset data=%h/800 clk=%b/0 und=%b/0 lvl=%0d/0", dac_data, dac_clk, underrun, fifo_level);
    end
    enable = 0;
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
    clk_step();
    total++; if (s_ready !== 1'b1 || fifo_level !== 0) begin bad++; $display("FAIL async_after ready=%b/1 lvl=%0d/0", s_ready, fifo_level); end
    total++; if (dac_data !== MID) begin bad++; $display("FAIL async_after_data got=%h exp=800", dac_data); end
  endtask

  initial begin
    test_reset();
    test_empty_playout();
    test_playout_sequence();
    test_full();
    test_rate0();
    test_underrun_clr();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
